// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, flag layout, FSM encoding, command record.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package alu_pkg;

  localparam int FLAGS_W = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  // Flag bit positions within {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int FLG_INV = 4;
  localparam int FLG_DZ  = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Flags reported for operations that never reach (or never return from) the ALU
  localparam logic [FLAGS_W-1:0] FLAGS_INV = FLAGS_W'(1) << FLG_INV;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Operation fields as stored in the command FIFO; the user tag is appended after it
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        mode;
    logic        round;
  } op_t;

  localparam int OP_W = $bits(op_t);

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Half precision only uses the low 16 bits; the upper half is forced to zero
  function automatic logic [31:0] hp_mask(input logic [31:0] v, input logic sp);
    return sp ? v : {16'h0000, v[15:0]};
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO with occupancy count, full and empty.
// Latency: a pushed word is visible at pop_dat the cycle after the push edge.
// Backpressure: caller gates push with full (push+pop when full is allowed); pop must not be issued when empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array: written on push, no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the FP ALU: queues commands, runs one ALU start/valid_out handshake at a time, returns tagged results.
// Latency: command into an empty idle block raises alu_start one cycle after the push edge; ALU answer -> rsp_valid >= 2 cycles.
// Backpressure: cmd_ready drops only when the FIFO is full and no pop is happening; rsp held stable until rsp_ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_a,
  input  logic [31:0]        cmd_b,
  input  logic [2:0]         cmd_op,
  input  logic               cmd_mode,
  input  logic               cmd_round,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic [31:0]        alu_op_a,
  output logic [31:0]        alu_op_b,
  output logic [2:0]         alu_op_code,
  output logic               alu_mode_fp,
  output logic               alu_round_mode,
  output logic               alu_start,
  input  logic [31:0]        alu_result,
  input  logic               alu_valid_out,
  input  logic [FLAGS_W-1:0] alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_result,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_timeout,
  output logic [FLAGS_W-1:0] sticky_flags,
  input  logic               sticky_clr,
  output logic               busy
);

  localparam int FW   = OP_W + TAG_W;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t                 state;
  logic [WD_W-1:0]        wdog;
  logic [FW-1:0]          fifo_in;
  logic [FW-1:0]          fifo_out;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   rsp_hs;
  op_t                    head;
  logic [TAG_W-1:0]       head_tag;

  assign fifo_in          = {cmd_a, cmd_b, cmd_op, cmd_mode, cmd_round, cmd_tag};
  assign {head, head_tag} = fifo_out;

  // The head leaves the FIFO on the cycle the FSM picks it up from IDLE
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full || pop;
  assign push      = cmd_valid && cmd_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign busy      = (fifo_count != '0) || (state != ST_IDLE);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (fifo_in),
    .pop      (pop),
    .pop_dat  (fifo_out),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Issue FSM: owns the ALU drive, the watchdog and the registered response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      wdog           <= '0;
      alu_op_a       <= '0;
      alu_op_b       <= '0;
      alu_op_code    <= '0;
      alu_mode_fp    <= 1'b0;
      alu_round_mode <= 1'b0;
      alu_start      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_flags      <= '0;
      rsp_tag        <= '0;
      rsp_timeout    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_op_a       <= hp_mask(head.a, head.mode);
            alu_op_b       <= hp_mask(head.b, head.mode);
            alu_op_code    <= head.op;
            alu_mode_fp    <= head.mode;
            alu_round_mode <= head.round;
            rsp_tag        <= head_tag;
            rsp_timeout    <= 1'b0;
            wdog           <= '0;
            if (op_legal(head.op)) begin
              alu_start <= 1'b1;
              state     <= ST_ISSUE;
            end else begin
              // Illegal op is answered locally without touching the ALU
              rsp_result <= '0;
              rsp_flags  <= FLAGS_INV;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          if (alu_valid_out) begin
            alu_start  <= 1'b0;
            rsp_result <= hp_mask(alu_result, alu_mode_fp);
            rsp_flags  <= alu_flags;
            wdog       <= '0;
            state      <= ST_DRAIN;
          end else if (wdog == WD_LAST) begin
            alu_start   <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= FLAGS_INV;
            rsp_timeout <= 1'b1;
            wdog        <= '0;
            state       <= ST_DRAIN;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Wait for the ALU to release valid_out so the next start is seen as a new operation
          if (!alu_valid_out) begin
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (wdog == WD_LAST) begin
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky exception flags: a clear coinciding with a handshake keeps only the new flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_flags <= '0;
    end else if (sticky_clr || rsp_hs) begin
      sticky_flags <= (sticky_clr ? '0 : sticky_flags) | (rsp_hs ? rsp_flags : '0);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU stub and a queue-based response model.
// Latency: directed steps check start latency, ordering, timeout length and reset behaviour.
// Backpressure: exercised with a stalled response port and randomised rsp_ready.
module tb_alu_issue_ctrl;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [31:0]       cmd_a = '0;
  logic [31:0]       cmd_b = '0;
  logic [2:0]        cmd_op = '0;
  logic              cmd_mode = 1'b0;
  logic              cmd_round = 1'b0;
  logic [TAG_W-1:0]  cmd_tag = '0;
  logic [31:0]       alu_op_a;
  logic [31:0]       alu_op_b;
  logic [2:0]        alu_op_code;
  logic              alu_mode_fp;
  logic              alu_round_mode;
  logic              alu_start;
  logic [31:0]       alu_result;
  logic              alu_valid_out;
  logic [4:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_result;
  logic [4:0]        rsp_flags;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_timeout;
  logic [4:0]        sticky_flags;
  logic              sticky_clr = 1'b0;
  logic              busy;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_round(cmd_round), .cmd_tag(cmd_tag),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_valid_out(alu_valid_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .busy(busy)
  );

  // ALU behaviour: known IEEE vectors, otherwise a deterministic scramble (HP upper half left dirty)
  function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic mode, input logic rnd);
    logic [31:0] r;
    logic [4:0]  f;
    if (mode && op == 3'd0 && a == 32'h40000000 && b == 32'h40000000) return {5'b00000, 32'h40800000};
    if (!mode && op == 3'd1 && a == 32'h00004200 && b == 32'h00004000) return {5'b00000, 32'hA5A53C00};
    if (mode && op == 3'd3 && a == 32'h40000000 && b == 32'h00000000) return {5'b01000, 32'h7F800000};
    r = (a * 32'd3) ^ {b[15:0], b[31:16]} ^ {16'h0000, a[31:16]} ^ {29'd0, op} ^ {31'd0, rnd};
    f = r[4:0] ^ a[9:5];
    if (!mode) r[31:16] = r[31:16] | 16'hA5A5;
    return {f, r};
  endfunction

  // ALU stub: random start-to-valid latency and valid_out hold; can be made unresponsive
  logic alu_dead = 1'b0;
  int   stub_phase;
  int   stub_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_valid_out <= 1'b0;
      alu_result    <= '0;
      alu_flags     <= '0;
      stub_phase    <= 0;
      stub_cnt      <= 0;
    end else begin
      case (stub_phase)
        0: if (alu_start && !alu_dead) begin
             stub_cnt   <= int'($urandom_range(0, 3));
             stub_phase <= 1;
           end
        1: if (stub_cnt == 0) begin
             {alu_flags, alu_result} <= alu_fn(alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode);
             alu_valid_out <= 1'b1;
             stub_cnt      <= int'($urandom_range(0, 2));
             stub_phase    <= 2;
           end else stub_cnt <= stub_cnt - 1;
        default: if (stub_cnt == 0) begin
             alu_valid_out <= 1'b0;
             stub_phase    <= 0;
           end else stub_cnt <= stub_cnt - 1;
      endcase
    end
  end

  // alu_start observation
  int start_cycles = 0;
  bit start_seen   = 1'b0;
  always @(posedge clk) begin
    if (alu_start) begin
      start_cycles = start_cycles + 1;
      start_seen   = 1'b1;
    end
  end

  typedef struct {
    logic [31:0]      r;
    logic [4:0]       f;
    logic [TAG_W-1:0] t;
    logic             to;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] sticky_m = '0;
  int         checks   = 0;
  int         failures = 0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                 input logic mode, input logic rnd, input logic [TAG_W-1:0] tag,
                                 input logic dead);
    exp_t        e;
    logic [36:0] fr;
    logic [31:0] am;
    logic [31:0] bm;
    e.t  = tag;
    e.to = 1'b0;
    if (op > 3'd3) begin
      e.r = '0;
      e.f = 5'b10000;
    end else if (dead) begin
      e.r  = '0;
      e.f  = 5'b10000;
      e.to = 1'b1;
    end else begin
      am  = mode ? a : {16'h0000, a[15:0]};
      bm  = mode ? b : {16'h0000, b[15:0]};
      fr  = alu_fn(am, bm, op, mode, rnd);
      e.f = fr[36:32];
      e.r = mode ? fr[31:0] : {16'h0000, fr[15:0]};
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic mode, input logic rnd, input logic [TAG_W-1:0] tag);
    bit ok;
    ok        = 1'b0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_mode  = mode;
    cmd_round = rnd;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      ok = cmd_ready;
      tick();
      if (ok) exp_q.push_back(model(a, b, op, mode, rnd, tag, alu_dead));
    end
    cmd_valid = 1'b0;
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic get_rsp(input bit rnd_rdy);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        got = 1'b1;
        chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_result",  rsp_result,        e.r);
          chk("rsp_flags",   32'(rsp_flags),    32'(e.f));
          chk("rsp_tag",     32'(rsp_tag),      32'(e.t));
          chk("rsp_timeout", 32'(rsp_timeout),  32'(e.to));
          sticky_m = (sticky_clr ? 5'b00000 : sticky_m) | e.f;
        end
      end
      tick();
    end
    rsp_ready = 1'b0;
    chk("rsp_arrived", 32'(got), 32'd1);
    if (got) begin
      chk("rsp_valid_fall", 32'(rsp_valid), 32'd0);
      chk("sticky",         32'(sticky_flags), 32'(sticky_m));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_sticky",    32'(sticky_flags), 32'd0);
    chk("rst_alu_op_a",  alu_op_a, 32'd0);
    rst = 1'b1;
    tick();

    // SP add, start latency
    push(32'h40000000, 32'h40000000, 3'b000, 1'b1, 1'b0, 4'd3);
    chk("t1_start_pre", 32'(alu_start), 32'd0);
    tick();
    chk("t1_start_lat", 32'(alu_start), 32'd1);
    chk("t1_busy",      32'(busy),      32'd1);
    get_rsp(1'b0);

    // HP sub with dirty upper operand bits
    push(32'hFFFF4200, 32'hFFFF4000, 3'b001, 1'b0, 1'b0, 4'd5);
    tick();
    chk("t2_alu_op_a", alu_op_a, 32'h00004200);
    chk("t2_alu_op_b", alu_op_b, 32'h00004000);
    get_rsp(1'b0);

    // SP divide by zero, sticky persistence and clear
    push(32'h40000000, 32'h00000000, 3'b011, 1'b1, 1'b0, 4'd6);
    get_rsp(1'b0);
    chk("t3_sticky_dz", 32'(sticky_flags), 32'h08);
    repeat (3) tick();
    chk("t3_sticky_hold", 32'(sticky_flags), 32'h08);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    sticky_m   = 5'b00000;
    chk("t3_sticky_clr", 32'(sticky_flags), 32'h00);

    // Illegal op never starts the ALU
    start_seen = 1'b0;
    push(32'h12345678, 32'h9ABCDEF0, 3'b111, 1'b1, 1'b0, 4'd7);
    get_rsp(1'b0);
    chk("t5_no_start", 32'(start_seen), 32'd0);
    chk("t5_sticky_inv", 32'(sticky_flags), 32'h10);

    // Clear and handshake in the same cycle keep only the new flags
    sticky_clr = 1'b1;
    push(32'h40000000, 32'h00000000, 3'b011, 1'b1, 1'b0, 4'd8);
    get_rsp(1'b0);
    sticky_clr = 1'b0;
    chk("t3_clr_and_hs", 32'(sticky_flags), 32'h08);

    // Backpressure: 1 in flight + 4 queued, 6th must wait
    for (int i = 0; i < 5; i++) push($urandom, $urandom, 3'(i % 4), 1'b1, 1'b0, 4'(i));
    cmd_valid = 1'b1;
    repeat (10) tick();
    chk("t4_full",      32'(cmd_ready), 32'd0);
    chk("t4_busy",      32'(busy),      32'd1);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    cmd_valid = 1'b0;
    fork
      push($urandom, $urandom, 3'd2, 1'b1, 1'b1, 4'd5);
      begin
        for (int i = 0; i < 6; i++) get_rsp(1'b0);
      end
    join

    // Timeout with an unresponsive ALU
    alu_dead     = 1'b1;
    start_cycles = 0;
    push(32'h3F800000, 32'h3F800000, 3'b010, 1'b1, 1'b0, 4'd9);
    get_rsp(1'b0);
    chk("t5_start_cycles", 32'(start_cycles), 32'(TIMEOUT));
    alu_dead = 1'b0;

    // Reset in the middle of ISSUE
    alu_dead = 1'b1;
    push(32'h3F800000, 32'h40000000, 3'b000, 1'b1, 1'b0, 4'd10);
    repeat (3) tick();
    chk("t6_pre_start", 32'(alu_start), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_alu_start", 32'(alu_start), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_busy",      32'(busy),      32'd0);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    sticky_m = 5'b00000;
    chk("t6_sticky", 32'(sticky_flags), 32'd0);
    tick();
    rst      = 1'b1;
    alu_dead = 1'b0;
    tick();
    push(32'h40400000, 32'h3F800000, 3'b001, 1'b1, 1'b1, 4'd11);
    get_rsp(1'b0);

    // Randomised traffic with random response backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [2:0] op;
          repeat ($urandom_range(0, 2)) tick();
          op = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
          push($urandom, $urandom, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
        end
      end
      begin
        for (int i = 0; i < 40; i++) get_rsp(1'b1);
      end
    join

    tick();
    chk("end_idle",        32'(busy), 32'd0);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
